// File: rtl/core_pkg.sv
// Shared types and constants for the rv32imc core pipeline control.
// Contents:
//   ctrl_state_e  - sequencer FSM states (RUN, MD_WAIT)
//   pipe_ctrl_t   - bundle of PC/pipeline-register enable and flush bits, consumed by the
//                   PC and the IF/DE, DE/EX, EX/MEM and MEM/WB registers
//   REG_ZERO      - architectural x0 index (never a real dependency)
//   CTRL_RUN      - free-running control word (everything advances, nothing flushed)
//   CTRL_RESET    - control word held while reset is asserted
package core_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } ctrl_state_e;

    typedef struct packed {
        logic pc_en;
        logic fetch_redirect;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } pipe_ctrl_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_en:          1'b1,
        fetch_redirect: 1'b0,
        ifid_en:        1'b1,
        idex_en:        1'b1,
        exmem_en:       1'b1,
        memwb_en:       1'b1,
        ifid_flush:     1'b0,
        idex_flush:     1'b0,
        exmem_flush:    1'b0,
        memwb_flush:    1'b0
    };

    localparam pipe_ctrl_t CTRL_RESET = '{
        pc_en:          1'b0,
        fetch_redirect: 1'b0,
        ifid_en:        1'b0,
        idex_en:        1'b0,
        exmem_en:       1'b0,
        memwb_en:       1'b0,
        ifid_flush:     1'b1,
        idex_flush:     1'b1,
        exmem_flush:    1'b1,
        memwb_flush:    1'b1
    };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags a DE instruction that reads the destination of a load
// currently in EX (the load data is not available for forwarding until MEM completes).
// Ports:
//   de_rs1/de_rs2          - DE-stage source register indices
//   de_uses_rs1/rs2        - DE instruction actually reads that source
//   ex_valid, ex_is_load   - EX holds a valid load
//   ex_rd                  - EX destination register
//   load_use               - one-cycle stall required
module hazard_detect
    import core_pkg::*;
(
    input  logic [4:0] de_rs1,
    input  logic [4:0] de_rs2,
    input  logic       de_uses_rs1,
    input  logic       de_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = de_uses_rs1 & (de_rs1 == ex_rd);
    assign rs2_hit  = de_uses_rs2 & (de_rs2 == ex_rd);
    // x0 is hardwired, so a load targeting it creates no dependency.
    assign load_use = ex_valid & ex_is_load & (ex_rd != REG_ZERO) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage core (IF, DE, EX, MEM, WB).
// Combines data-memory wait-states, multi-cycle mul/div, EX redirects, load-use hazards and
// instruction-memory wait-states into enable/flush controls for the PC and the four
// pipeline registers. Also drops the one fetch response made stale by a redirect and counts
// cycles in which the PC was held.
// Ports:
//   clk, arst                      - clock, asynchronous active-high reset
//   de_*, ex_valid/is_load/rd      - operands for the load-use compare
//   ex_muldiv_start, muldiv_done   - mul/div op in EX, 1-cycle result pulse
//   ex_redirect                    - EX resolved a taken branch/jump
//   mem_req, dmem_ready            - MEM access and its completion
//   imem_ready                     - fetch response this cycle
//   pc_en, fetch_redirect          - PC update enable, PC mux selects EX target
//   *_en, *_flush                  - pipeline register load enable / load bubble
//   stall_cnt                      - saturating count of cycles with pc_en=0
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_uses_rs1,
    input  logic             de_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_muldiv_start,
    input  logic             muldiv_done,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             fetch_redirect,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_state_e      state;
    ctrl_state_e      state_next;
    logic             md_done_q;
    logic             md_done_next;
    logic             drop_fetch;
    logic             drop_next;
    logic [CNT_W-1:0] cnt_next;

    logic             load_use;
    logic             dm_stall;
    logic             md_stall;
    logic             md_in_ex;
    logic             md_exit;
    pipe_ctrl_t       ctrl;

    hazard_detect u_hazard_detect (
        .de_rs1      (de_rs1),
        .de_rs2      (de_rs2),
        .de_uses_rs1 (de_uses_rs1),
        .de_uses_rs2 (de_uses_rs2),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    assign dm_stall = mem_req & ~dmem_ready;
    // A mul/div op occupies EX either on its first sighting or for the whole wait.
    assign md_in_ex = ((state == RUN) & ex_muldiv_start) | (state == MD_WAIT);
    // In MD_WAIT a result captured earlier (during a dmem stall) releases the stall.
    assign md_stall = ((state == RUN) & ex_muldiv_start & ~muldiv_done)
                    | ((state == MD_WAIT) & ~muldiv_done & ~md_done_q);

    // Pipeline control, highest priority first.
    always_comb begin
        ctrl      = CTRL_RUN;
        drop_next = drop_fetch;
        // Any fetch response consumes the pending drop.
        if (imem_ready) begin
            drop_next = 1'b0;
        end
        if (arst) begin
            ctrl = CTRL_RESET;
        end else if (dm_stall) begin
            // Whole front end and EX frozen; a redirect in EX is re-presented later.
            ctrl.pc_en       = 1'b0;
            ctrl.ifid_en     = 1'b0;
            ctrl.idex_en     = 1'b0;
            ctrl.exmem_en    = 1'b0;
            ctrl.memwb_flush = 1'b1;
        end else if (md_stall) begin
            ctrl.pc_en       = 1'b0;
            ctrl.ifid_en     = 1'b0;
            ctrl.idex_en     = 1'b0;
            ctrl.exmem_flush = 1'b1;
        end else if (ex_redirect) begin
            ctrl.pc_en          = 1'b1;
            ctrl.fetch_redirect = 1'b1;
            ctrl.ifid_flush     = 1'b1;
            ctrl.idex_flush     = 1'b1;
            // The outstanding fetch belongs to the wrong path; discard its response.
            if (!imem_ready) begin
                drop_next = 1'b1;
            end
        end else if (load_use) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_en    = 1'b0;
            ctrl.idex_flush = 1'b1;
        end else if (!imem_ready || drop_fetch) begin
            ctrl.pc_en      = 1'b0;
            ctrl.ifid_flush = 1'b1;
        end
    end

    assign pc_en          = ctrl.pc_en;
    assign fetch_redirect = ctrl.fetch_redirect;
    assign ifid_en        = ctrl.ifid_en;
    assign idex_en        = ctrl.idex_en;
    assign exmem_en       = ctrl.exmem_en;
    assign memwb_en       = ctrl.memwb_en;
    assign ifid_flush     = ctrl.ifid_flush;
    assign idex_flush     = ctrl.idex_flush;
    assign exmem_flush    = ctrl.exmem_flush;
    assign memwb_flush    = ctrl.memwb_flush;

    // The op leaves EX only when EX/MEM loads real data, not a bubble.
    assign md_exit = ctrl.exmem_en & ~ctrl.exmem_flush;

    always_comb begin
        state_next   = state;
        md_done_next = md_done_q;
        case (state)
            RUN: begin
                if (ex_muldiv_start && (!muldiv_done || dm_stall)) begin
                    state_next = MD_WAIT;
                end
            end
            MD_WAIT: begin
                if (md_exit) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
        // Result arrived while MEM held EX frozen; remember it until the op can retire.
        if (md_in_ex && muldiv_done && dm_stall) begin
            md_done_next = 1'b1;
        end
        if ((state == MD_WAIT) && md_exit) begin
            md_done_next = 1'b0;
        end
    end

    always_comb begin
        cnt_next = stall_cnt;
        if (!ctrl.pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
            cnt_next = stall_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= RUN;
            md_done_q  <= 1'b0;
            drop_fetch <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            state      <= state_next;
            md_done_q  <= md_done_next;
            drop_fetch <= drop_next;
            stall_cnt  <= cnt_next;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: expected control words are queued as each cycle's
// stimulus is driven and popped when the outputs are sampled on the falling edge.
module tb_hazard_ctrl;
    import core_pkg::*;

    // {pc_en, fetch_redirect, ifid/idex/exmem/memwb_en, ifid/idex/exmem/memwb_flush}
    localparam logic [9:0] V_IDLE  = 10'b1_0_1111_0000;
    localparam logic [9:0] V_RST   = 10'b0_0_0000_1111;
    localparam logic [9:0] V_LU    = 10'b0_0_0111_0100;
    localparam logic [9:0] V_MD    = 10'b0_0_0011_0010;
    localparam logic [9:0] V_DM    = 10'b0_0_0001_0001;
    localparam logic [9:0] V_REDIR = 10'b1_1_1111_1100;
    localparam logic [9:0] V_IWAIT = 10'b0_0_1111_1000;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [4:0]  de_rs1, de_rs2, ex_rd;
    logic        de_uses_rs1, de_uses_rs2, ex_valid, ex_is_load;
    logic        ex_muldiv_start, muldiv_done, ex_redirect, mem_req, dmem_ready, imem_ready;

    logic        pc_en, fetch_redirect, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic [15:0] stall_cnt;
    logic        pc_en4, fetch_redirect4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
    logic        ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4;
    logic [3:0]  stall_cnt4;

    logic [9:0]  exp_q[$];
    logic [9:0]  e;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .arst(arst), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_uses_rs1(de_uses_rs1), .de_uses_rs2(de_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_muldiv_start(ex_muldiv_start),
        .muldiv_done(muldiv_done), .ex_redirect(ex_redirect), .mem_req(mem_req),
        .dmem_ready(dmem_ready), .imem_ready(imem_ready), .pc_en(pc_en),
        .fetch_redirect(fetch_redirect), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .arst(arst), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_uses_rs1(de_uses_rs1), .de_uses_rs2(de_uses_rs2), .ex_valid(ex_valid),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_muldiv_start(ex_muldiv_start),
        .muldiv_done(muldiv_done), .ex_redirect(ex_redirect), .mem_req(mem_req),
        .dmem_ready(dmem_ready), .imem_ready(imem_ready), .pc_en(pc_en4),
        .fetch_redirect(fetch_redirect4), .ifid_en(ifid_en4), .idex_en(idex_en4),
        .exmem_en(exmem_en4), .memwb_en(memwb_en4), .ifid_flush(ifid_flush4),
        .idex_flush(idex_flush4), .exmem_flush(exmem_flush4), .memwb_flush(memwb_flush4),
        .stall_cnt(stall_cnt4)
    );

    function automatic logic [9:0] observe();
        return {pc_en, fetch_redirect, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush};
    endfunction

    task automatic idle();
        de_rs1 = 5'd0; de_rs2 = 5'd0; de_uses_rs1 = 1'b0; de_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
        ex_muldiv_start = 1'b0; muldiv_done = 1'b0; ex_redirect = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        idle();
        exp_q.delete();
        @(posedge clk); #1;
        arst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        ex_redirect = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0; imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        exp_q.push_back(V_RST);
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (observe() !== e) $display("FAIL reset_vec got=%b want=%b", observe(), e);
        else passed++;
        total++;
        if (stall_cnt !== 16'd0) $display("FAIL reset_cnt got=%0d want=0", stall_cnt);
        else passed++;
        total++;
        if (dut.state !== RUN) $display("FAIL reset_state got=%0d want=%0d", dut.state, RUN);
        else passed++;
        @(posedge clk); #1;
        arst = 1'b0;
        idle();
    endtask

    task automatic test_load_use();
        logic [9:0] want [4] = '{V_LU, V_IDLE, V_IDLE, V_LU};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            ex_valid = 1'b1; ex_is_load = 1'b1;
            case (i)
                0: begin ex_rd = 5'd5; de_uses_rs2 = 1'b1; de_rs2 = 5'd5; end
                1: begin ex_rd = 5'd5; de_uses_rs2 = 1'b0; de_rs2 = 5'd5; end
                2: begin ex_rd = 5'd0; de_uses_rs2 = 1'b1; de_rs2 = 5'd0; end
                default: begin ex_rd = 5'd9; de_uses_rs1 = 1'b1; de_rs1 = 5'd9; end
            endcase
            exp_q.push_back(want[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) $display("FAIL load_use[%0d] got=%b want=%b", i, observe(), e);
            else passed++;
            @(posedge clk); #1;
        end
        idle();
        @(negedge clk);
        total++;
        if (stall_cnt !== 16'd2) $display("FAIL load_use_cnt got=%0d want=2", stall_cnt);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_muldiv();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            ex_muldiv_start = 1'b1; muldiv_done = (i == 4);
            exp_q.push_back((i < 4) ? V_MD : V_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) $display("FAIL muldiv[%0d] got=%b want=%b", i, observe(), e);
            else passed++;
            if (i == 2) begin
                total++;
                if (dut.state !== MD_WAIT)
                    $display("FAIL muldiv_state got=%0d want=%0d", dut.state, MD_WAIT);
                else passed++;
            end
            @(posedge clk); #1;
        end
        // Result in the start cycle: no stall, FSM stays in RUN.
        idle();
        ex_muldiv_start = 1'b1; muldiv_done = 1'b1;
        exp_q.push_back(V_IDLE);
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (observe() !== e) $display("FAIL muldiv_fast got=%b want=%b", observe(), e);
        else passed++;
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        total++;
        if (dut.state !== RUN) $display("FAIL muldiv_exit got=%0d want=%0d", dut.state, RUN);
        else passed++;
        total++;
        if (stall_cnt !== 16'd4) $display("FAIL muldiv_cnt got=%0d want=4", stall_cnt);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_dm_overlap();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            idle();
            mem_req = (i < 7); dmem_ready = (i >= 6);
            ex_muldiv_start = (i < 7); muldiv_done = (i == 2);
            exp_q.push_back((i < 6) ? V_DM : V_IDLE);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) $display("FAIL dm_overlap[%0d] got=%b want=%b", i, observe(), e);
            else passed++;
            if (i == 3) begin
                total++;
                if (dut.md_done_q !== 1'b1)
                    $display("FAIL dm_md_done got=%b want=1", dut.md_done_q);
                else passed++;
            end
            @(posedge clk); #1;
        end
        idle();
        @(negedge clk);
        total++;
        if (dut.state !== RUN || dut.md_done_q !== 1'b0)
            $display("FAIL dm_exit got=%0d/%b want=%0d/0", dut.state, dut.md_done_q, RUN);
        else passed++;
        total++;
        if (stall_cnt !== 16'd6) $display("FAIL dm_cnt got=%0d want=6", stall_cnt);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_redirect();
        logic [9:0] want [4] = '{V_REDIR, V_IWAIT, V_IWAIT, V_IDLE};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle();
            ex_redirect = (i == 0); imem_ready = (i >= 2);
            exp_q.push_back(want[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) $display("FAIL redirect[%0d] got=%b want=%b", i, observe(), e);
            else passed++;
            if (i == 1 || i == 3) begin
                total++;
                if (dut.drop_fetch !== (i == 1))
                    $display("FAIL redirect_drop[%0d] got=%b want=%b", i, dut.drop_fetch, i == 1);
                else passed++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (stall_cnt !== 16'd2) $display("FAIL redirect_cnt got=%0d want=2", stall_cnt);
        else passed++;
    endtask

    task automatic test_redirect_dm();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            ex_redirect = (i < 4); mem_req = (i < 4); dmem_ready = (i >= 3);
            exp_q.push_back((i < 3) ? V_DM : ((i == 3) ? V_REDIR : V_IDLE));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) $display("FAIL redirect_dm[%0d] got=%b want=%b", i, observe(), e);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        idle();
        ex_muldiv_start = 1'b1; mem_req = 1'b1; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ex_redirect = 1'b1;
        arst = 1'b1;
        exp_q.push_back(V_RST);
        #1;
        e = exp_q.pop_front();
        total++;
        if (observe() !== e) $display("FAIL midrst_vec got=%b want=%b", observe(), e);
        else passed++;
        total++;
        if (stall_cnt !== 16'd0 || dut.state !== RUN)
            $display("FAIL midrst_state got=%0d/%0d want=0/%0d", stall_cnt, dut.state, RUN);
        else passed++;
        @(posedge clk); #1;
        arst = 1'b0;
        // Leave a drop pending, then reset: it must not survive.
        idle();
        ex_redirect = 1'b1; imem_ready = 1'b0;
        @(posedge clk); #1;
        arst = 1'b1;
        @(posedge clk); #1;
        arst = 1'b0;
        idle();
        exp_q.push_back(V_IDLE);
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (observe() !== e) $display("FAIL midrst_release got=%b want=%b", observe(), e);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            idle();
            imem_ready = 1'b0;
            exp_q.push_back(V_IWAIT);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (observe() !== e) $display("FAIL sat_vec[%0d] got=%b want=%b", i, observe(), e);
            else passed++;
            @(posedge clk); #1;
        end
        idle();
        @(negedge clk);
        total++;
        if (stall_cnt4 !== 4'd15) $display("FAIL sat_cnt4 got=%0d want=15", stall_cnt4);
        else passed++;
        total++;
        if (stall_cnt !== 16'd20) $display("FAIL sat_cnt16 got=%0d want=20", stall_cnt);
        else passed++;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_muldiv();
        test_dm_overlap();
        test_redirect();
        test_redirect_dm();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
